// File: rtl/sm_im_pkg.sv
// Shared definitions for the instruction-memory controller: state encoding,
// default geometry and the saturating load counter helper.
package sm_im_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;

  localparam logic [15:0] LOAD_COUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == LOAD_COUNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/sm_im_clear_seq.sv
// Bulk-clear address sequencer: walks every word address once, ascending,
// starting the cycle after start and flagging the final address with done.
module sm_im_clear_seq
  import sm_im_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              active,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  // The last address of the sweep ends the clear.
  assign done = active && (addr == {ADDR_W{1'b1}});

  // Address counter and active flag; the counter wraps back to 0 after the last write.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent logic.
    if (!rst_n) begin
      active <= 1'b0;
      addr   <= '0;
    end else if (start) begin
      active <= 1'b1;
      addr   <= '0;
    end else if (active) begin
      addr <= addr + ADDR_ONE;
      if (done) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sm_im_ctrl.sv
// Instruction-memory owner: arbitrates the single memory port between the
// bulk-clear engine, the UART ROM writer and CPU fetch, stalling the CPU
// whenever it does not own the port. Also serves a debug read port in LOAD.
module sm_im_ctrl
  import sm_im_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                DATA_W      = DATA_W_DEF,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_mode,
  input  logic              clear_req,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              busy,
  output logic [15:0]       load_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state, state_nxt;

  logic              clr_start;
  logic              clr_active;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_done;

  logic              wr_accept;
  logic              dbg_read;
  logic              dbg_pend;
  logic              we_raw;
  logic [DATA_W-1:0] wdata_raw;

  // A clear request is honoured from RUN or LOAD; once clearing it is ignored.
  assign clr_start = clear_req && (state != ST_CLEAR);

  sm_im_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (clr_start),
    .active (clr_active),
    .addr   (clr_addr),
    .done   (clr_done)
  );

  assign busy      = clr_active;
  assign cpu_rdata = mem_rdata;

  // A low rst_n suppresses the write of the cycle it arrives in, so an
  // aborted clear leaves the current address untouched.
  // NOTE: the memory array itself is never reset; its contents only change
  // through the clear engine or ROM writes.
  assign mem_we    = we_raw & rst_n;
  assign mem_wdata = mem_we ? wdata_raw : '0;

  // Next-state decode and memory-port arbitration.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would infer a latch.
    state_nxt = state;
    wr_ready  = 1'b0;
    wr_accept = 1'b0;
    dbg_read  = 1'b0;
    cpu_stall = 1'b1;
    mem_addr  = cpu_addr;
    we_raw    = 1'b0;
    wdata_raw = '0;
    unique case (state)
      ST_RUN: begin
        cpu_stall = 1'b0;
        if (clear_req) begin
          state_nxt = ST_CLEAR;
        end else if (load_mode) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wr_ready  = ~clear_req;
        wr_accept = wr_valid & ~clear_req;
        if (wr_accept) begin
          mem_addr  = wr_addr;
          we_raw    = 1'b1;
          wdata_raw = wr_data;
        end else begin
          mem_addr = dbg_addr;
          dbg_read = 1'b1;
        end
        if (clear_req) begin
          state_nxt = ST_CLEAR;
        end else if (!load_mode) begin
          state_nxt = ST_RUN;
        end
      end
      ST_CLEAR: begin
        mem_addr  = clr_addr;
        we_raw    = 1'b1;
        wdata_raw = CLEAR_VALUE;
        if (clr_done) begin
          state_nxt = load_mode ? ST_LOAD : ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch data is valid the cycle after every cycle the CPU owned the port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= (state == ST_RUN);
    end
  end

  // Words accepted since entering LOAD from RUN; a clear does not disturb it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_count <= '0;
    end else if ((state == ST_RUN) && !clear_req && load_mode) begin
      load_count <= '0;
    end else if (wr_accept) begin
      load_count <= sat_inc16(load_count);
    end
  end

  // Debug read: capture memory data one cycle after each LOAD read cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dbg_pend  <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_pend <= dbg_read;
      if (dbg_pend) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sm_im_ctrl.sv
// Self-checking bench for sm_im_ctrl with a 16-word memory model.
module tb_sm_im_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_mode, clear_req, wr_valid;
  logic [AW-1:0] wr_addr, cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] wr_data, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic          wr_ready, cpu_rvalid, cpu_stall, busy, mem_we;
  logic [15:0]   load_count;

  // Backdoor preload port into the memory model.
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  int            exp_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          exp_ready;
    logic          exp_we;
  } load_vec_t;

  load_vec_t vecs [4];

  always #5 clk = ~clk;

  sm_im_ctrl #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .CLEAR_VALUE (32'h0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_mode  (load_mode),
    .clear_req  (clear_req),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .cpu_addr   (cpu_addr),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_stall  (cpu_stall),
    .dbg_addr   (dbg_addr),
    .dbg_rdata  (dbg_rdata),
    .busy       (busy),
    .load_count (load_count),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Single-port synchronous memory, read-before-write, 1-cycle latency.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // Compare the memory the DUT wrote against the expected image.
  task automatic check_image(input string name);
    int bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (mem[a] !== exp_mem[a]) begin
        bad++;
        $display("FAIL %s: mem[%0d] got %0h expected %0h", name, a, mem[a], exp_mem[a]);
      end
    end
    checks++;
    if (bad != 0) errors++;
  endtask

  function automatic int sat_add(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  initial begin
    logic [DW-1:0] exp_dbg, prev_val, this_val;
    logic          prev_read, this_read;
    logic [DW-1:0] saved [DEPTH];
    int            saved_count;
    int            n;

    vecs[0] = '{1'b1, 4'd0, 32'hA,         1'b1, 1'b1};
    vecs[1] = '{1'b1, 4'd1, 32'hB,         1'b1, 1'b1};
    vecs[2] = '{1'b1, 4'd2, 32'hC,         1'b1, 1'b1};
    vecs[3] = '{1'b0, 4'd9, 32'hDEAD_BEEF, 1'b1, 1'b0};

    rst_n = 1'b0; load_mode = 1'b0; clear_req = 1'b0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; cpu_addr = '0; dbg_addr = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;

    // Preload memory through the backdoor while reset is held.
    for (int a = 0; a < DEPTH; a++) begin
      bd_we = 1'b1;
      bd_addr = AW'(a);
      bd_data = (a == 5) ? 32'h1234_5678 : $urandom;
      exp_mem[a] = bd_data;
      tick();
    end
    bd_we = 1'b0;
    tick();

    // Reset state.
    check("rst_busy", busy, 0);
    check("rst_load_count", load_count, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_mem_we", mem_we, 0);

    // RUN fetch from preloaded address 5.
    rst_n = 1'b1;
    cpu_addr = 4'd5;
    settle();
    check("run_stall", cpu_stall, 0);
    check("run_mem_addr", mem_addr, 5);
    check("run_mem_wdata", mem_wdata, 0);
    tick();
    check("run_rvalid", cpu_rvalid, 1);
    check("run_rdata", cpu_rdata, 32'h1234_5678);

    // Random fetches against the expected image.
    for (int i = 0; i < 20; i++) begin
      cpu_addr = AW'($urandom_range(0, DEPTH - 1));
      tick();
      check("fetch_rvalid", cpu_rvalid, 1);
      check("fetch_rdata", cpu_rdata, exp_mem[cpu_addr]);
    end

    // Enter LOAD; counter starts at zero.
    load_mode = 1'b1;
    tick();
    exp_count = 0;
    check("load_entry_count", load_count, 0);
    settle();
    check("load_stall", cpu_stall, 1);
    check("load_rvalid_drop", cpu_rvalid, 1);
    tick();
    check("load_rvalid_zero", cpu_rvalid, 0);

    // Table-driven writes.
    for (int i = 0; i < 4; i++) begin
      wr_valid = vecs[i].wr_valid;
      wr_addr  = vecs[i].wr_addr;
      wr_data  = vecs[i].wr_data;
      settle();
      check("vec_wr_ready", wr_ready, vecs[i].exp_ready);
      check("vec_mem_we", mem_we, vecs[i].exp_we);
      check("vec_stall", cpu_stall, 1);
      if (wr_valid) begin
        exp_mem[wr_addr] = wr_data;
        exp_count = sat_add(exp_count);
      end
      tick();
      check("vec_load_count", load_count, 64'(exp_count));
    end
    wr_valid = 1'b0;
    check_image("vec_image");

    // Debug read of address 1 appears two edges later.
    dbg_addr = 4'd1;
    tick();
    tick();
    check("dbg_read_b", dbg_rdata, 32'hB);

    // Random LOAD traffic with debug reads interleaved.
    exp_dbg = 32'hB; prev_read = 1'b1; prev_val = exp_mem[1];
    for (int i = 0; i < 200; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = AW'($urandom_range(0, DEPTH - 1));
      wr_data  = $urandom;
      dbg_addr = AW'($urandom_range(0, DEPTH - 1));
      settle();
      check("rnd_wr_ready", wr_ready, 1);
      check("rnd_mem_we", mem_we, wr_valid);
      this_read = !wr_valid;
      this_val  = exp_mem[dbg_addr];
      if (wr_valid) begin
        exp_mem[wr_addr] = wr_data;
        exp_count = sat_add(exp_count);
      end
      tick();
      if (prev_read) exp_dbg = prev_val;
      check("rnd_dbg_rdata", dbg_rdata, exp_dbg);
      check("rnd_load_count", load_count, 64'(exp_count));
      prev_read = this_read;
      prev_val  = this_val;
    end
    wr_valid = 1'b0;
    check_image("rnd_image");

    // Clear request collides with a write in LOAD: write refused.
    saved_count = exp_count;
    clear_req = 1'b1; wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 32'h5555_5555;
    settle();
    check("collide_wr_ready", wr_ready, 0);
    check("collide_mem_we", mem_we, 0);
    tick();
    clear_req = 1'b0; wr_valid = 1'b0;
    check("clr_busy_first", busy, 1);
    for (int i = 0; i < DEPTH; i++) begin
      clear_req = (i >= 3 && i <= 5);
      settle();
      check("clr_addr", mem_addr, 64'(i));
      check("clr_we", mem_we, 1);
      check("clr_wdata", mem_wdata, 0);
      check("clr_stall", cpu_stall, 1);
      tick();
    end
    clear_req = 1'b0;
    for (int a = 0; a < DEPTH; a++) exp_mem[a] = '0;
    check("clr_busy_end", busy, 0);
    check("clr_back_load_count", load_count, 64'(saved_count));
    settle();
    check("clr_back_load_ready", wr_ready, 1);
    check("clr_back_load_stall", cpu_stall, 1);
    check_image("clr_image");

    // Clear from RUN: busy for exactly DEPTH cycles.
    load_mode = 1'b0;
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check("run_clr_busy_cycles", n, DEPTH);
    check("run_clr_stall_after", cpu_stall, 0);
    check("run_clr_we_after", mem_we, 0);

    // Fill memory with non-zero data, then abort a clear at address 7.
    load_mode = 1'b1;
    tick();
    for (int a = 0; a < DEPTH; a++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(a);
      wr_data  = $urandom | 32'h1;
      exp_mem[a] = wr_data;
      tick();
    end
    wr_valid = 1'b0;
    load_mode = 1'b0;
    tick();
    tick();
    for (int a = 0; a < DEPTH; a++) saved[a] = mem[a];
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    settle();
    check("abort_at_addr", mem_addr, 7);
    rst_n = 1'b0;
    settle();
    check("abort_we_in_reset", mem_we, 0);
    tick();
    check("abort_busy", busy, 0);
    check("abort_stall", cpu_stall, 0);
    check("abort_we", mem_we, 0);
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < DEPTH; a++) exp_mem[a] = (a < 7) ? '0 : saved[a];
    check_image("abort_image");

    // Saturation of the load counter, then reset on re-entry.
    load_mode = 1'b1;
    tick();
    exp_count = 0;
    wr_valid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_data = $urandom;
      tick();
      exp_count = sat_add(exp_count);
      if (i == 65533) check("sat_fffe", load_count, 64'(exp_count));
    end
    check("sat_ffff", load_count, 16'hFFFF);
    wr_valid = 1'b0;
    load_mode = 1'b0;
    tick();
    check("sat_hold_exit", load_count, 16'hFFFF);
    load_mode = 1'b1;
    tick();
    check("sat_reentry_clear", load_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
